// File: rtl/regfile_wb_sched_if.sv
// Issue, regfile-port and writeback signals of the register-file issue/writeback scheduler.
// The slave modport is the scheduler's view; master is the driving environment.
interface regfile_wb_sched_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic                 iss_valid;
  logic                 iss_ready;
  logic [AW-1:0]        iss_rs1;
  logic [AW-1:0]        iss_rs2;
  logic                 iss_rs1_used;
  logic                 iss_rs2_used;
  logic [AW-1:0]        iss_rd;
  logic                 iss_rd_wr;

  logic                 rf_rd_en1;
  logic                 rf_rd_en2;
  logic [AW-1:0]        rf_rd_addr1;
  logic [AW-1:0]        rf_rd_addr2;

  logic [NREQ-1:0]      wb_valid;
  logic [NREQ*AW-1:0]   wb_addr;
  logic [NREQ*XLEN-1:0] wb_data;
  logic [NREQ-1:0]      wb_ready;

  logic                 rf_wr_en;
  logic [AW-1:0]        rf_wr_addr;
  logic [XLEN-1:0]      rf_wr_data;

  logic [(1<<AW)-1:0]   busy;
  logic [AW:0]          pending_cnt;
  logic                 wb_err;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rs1_used, iss_rs2_used, iss_rd, iss_rd_wr,
    output wb_valid, wb_addr, wb_data,
    input  iss_ready, rf_rd_en1, rf_rd_en2, rf_rd_addr1, rf_rd_addr2,
    input  wb_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
    input  busy, pending_cnt, wb_err
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rs1_used, iss_rs2_used, iss_rd, iss_rd_wr,
    input  wb_valid, wb_addr, wb_data,
    output iss_ready, rf_rd_en1, rf_rd_en2, rf_rd_addr1, rf_rd_addr2,
    output wb_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
    output busy, pending_cnt, wb_err
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Issue/writeback controller for a 2R/1W register file: busy scoreboard with
// RAW/WAW issue stall and round-robin arbitration of writeback units onto the write port.
module regfile_wb_sched #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_sched_if.slave  bus
);
  localparam int NREG = 1 << AW;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [AW:0]     pending_q;
  logic            wb_err_q;

  logic            haz;
  logic            set_en;
  logic            clr_en;
  logic            clr_live;
  logic            gnt_any;
  logic            gnt_live;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  // Issue side: r0 is never busy, so it can never raise a hazard.
  assign haz = (bus.iss_rs1_used & busy_q[bus.iss_rs1])
             | (bus.iss_rs2_used & busy_q[bus.iss_rs2])
             | (bus.iss_rd_wr    & busy_q[bus.iss_rd]);

  assign bus.iss_ready   = ~rst & ~haz;
  assign bus.rf_rd_en1   = bus.iss_valid & bus.iss_rs1_used;
  assign bus.rf_rd_en2   = bus.iss_valid & bus.iss_rs2_used;
  assign bus.rf_rd_addr1 = bus.iss_rs1;
  assign bus.rf_rd_addr2 = bus.iss_rs2;

  assign set_en = bus.iss_valid & bus.iss_ready & bus.iss_rd_wr & (bus.iss_rd != '0);

  // Round-robin search: distance k from rr_ptr is the outer loop so the nearest valid unit wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_any && bus.wb_valid[i] && (((int'(rr_ptr) + k) % NREQ) == i)) begin
          gnt_any   = 1'b1;
          gnt_idx   = PW'(i);
          gnt_oh[i] = 1'b1;
        end
      end
    end
  end

  assign gnt_live = gnt_any & ~rst;

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        wr_addr = bus.wb_addr[i*AW +: AW];
        wr_data = bus.wb_data[i*XLEN +: XLEN];
      end
    end
  end

  // A grant to r0 is consumed without a write or scoreboard change.
  assign clr_en   = gnt_live & (wr_addr != '0);
  assign clr_live = clr_en & busy_q[wr_addr];

  assign bus.wb_ready    = gnt_live ? gnt_oh : '0;
  assign bus.rf_wr_en    = clr_en;
  assign bus.rf_wr_addr  = wr_addr;
  assign bus.rf_wr_data  = wr_data;
  assign bus.busy        = busy_q;
  assign bus.pending_cnt = pending_q;
  assign bus.wb_err      = wb_err_q;

  // A set on the same register as a clear wins; only reachable after a spurious writeback.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[wr_addr] = 1'b0;
    if (set_en) busy_nxt[bus.iss_rd] = 1'b1;
  end

  // State update boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      rr_ptr    <= '0;
      pending_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (gnt_any) rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_ONE;
      if (set_en && !clr_live)      pending_q <= pending_q + CNT_ONE;
      else if (!set_en && clr_live) pending_q <= pending_q - CNT_ONE;
      if (clr_en && !busy_q[wr_addr]) wb_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scenario bench for regfile_wb_sched: expected writes queued at stimulus time, popped on rf_wr_en.
module tb_regfile_wb_sched;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  wr_t  sb[$];
  wr_t  e;
  logic [31:0] m_busy;

  regfile_wb_sched_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

  regfile_wb_sched #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid    = 1'b0;
    bus.iss_rs1      = '0;
    bus.iss_rs2      = '0;
    bus.iss_rs1_used = 1'b0;
    bus.iss_rs2_used = 1'b0;
    bus.iss_rd       = '0;
    bus.iss_rd_wr    = 1'b0;
    bus.wb_valid     = '0;
    bus.wb_addr      = '0;
    bus.wb_data      = '0;
  endtask

  task automatic drive_issue(input logic [AW-1:0] rd);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = rd;
    bus.iss_rd_wr = 1'b1;
  endtask

  task automatic set_wb(input int u, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.wb_addr[u*AW +: AW]     = a;
    bus.wb_data[u*XLEN +: XLEN] = d;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_t x;
    x.a = a;
    x.d = d;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    drive_issue(5'd5);
    bus.wb_valid = 3'b111;
    bus.wb_addr  = {5'd3, 5'd2, 5'd1};
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.wb_ready !== 3'b000) begin
        errors++; $display("FAIL reset_wb_ready: got %b expected 000", bus.wb_ready);
      end
      checks++;
      if (bus.rf_wr_en !== 1'b0) begin
        errors++; $display("FAIL reset_rf_wr_en: got %b expected 0", bus.rf_wr_en);
      end
      checks++;
      if (bus.iss_ready !== 1'b0) begin
        errors++; $display("FAIL reset_iss_ready: got %b expected 0", bus.iss_ready);
      end
    end
    rst = 1'b0;
    idle();
    m_busy = '0;
    #1;
    checks++;
    if (bus.busy !== 32'h0) begin
      errors++; $display("FAIL reset_busy: got %h expected 0", bus.busy);
    end
    checks++;
    if (bus.pending_cnt !== 6'd0) begin
      errors++; $display("FAIL reset_pending: got %0d expected 0", bus.pending_cnt);
    end
    checks++;
    if (bus.wb_err !== 1'b0) begin
      errors++; $display("FAIL reset_wb_err: got %b expected 0", bus.wb_err);
    end
  endtask

  task automatic test_raw();
    drive_issue(5'd5);
    #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++; $display("FAIL raw_issue_ready: got %b expected 1", bus.iss_ready);
    end
    tick();
    m_busy[5] = 1'b1;
    checks++;
    if (bus.busy !== m_busy || bus.pending_cnt !== 6'd1) begin
      errors++; $display("FAIL raw_busy_set: got busy=%h cnt=%0d expected busy=%h cnt=1", bus.busy, bus.pending_cnt, m_busy);
    end
    bus.iss_rd_wr    = 1'b0;
    bus.iss_rd       = '0;
    bus.iss_rs1      = 5'd5;
    bus.iss_rs1_used = 1'b1;
    #1;
    checks++;
    if (bus.iss_ready !== 1'b0) begin
      errors++; $display("FAIL raw_stall: got %b expected 0", bus.iss_ready);
    end
    set_wb(1, 5'd5, 32'hDEADBEEF);
    bus.wb_valid = 3'b010;
    push_exp(5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (bus.iss_ready !== 1'b0) begin
      errors++; $display("FAIL raw_no_writethrough: got %b expected 0", bus.iss_ready);
    end
    checks++;
    if (bus.wb_ready !== 3'b010) begin
      errors++; $display("FAIL raw_grant: got %b expected 010", bus.wb_ready);
    end
    checks++;
    e = sb.pop_front();
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== e.a || bus.rf_wr_data !== e.d) begin
      errors++; $display("FAIL raw_write: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h", bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, e.a, e.d);
    end
    tick();
    bus.wb_valid = '0;
    m_busy[5] = 1'b0;
    #1;
    checks++;
    if (bus.busy !== m_busy || bus.pending_cnt !== 6'd0) begin
      errors++; $display("FAIL raw_busy_clear: got busy=%h cnt=%0d expected busy=%h cnt=0", bus.busy, bus.pending_cnt, m_busy);
    end
    checks++;
    if (bus.iss_ready !== 1'b1 || bus.rf_rd_en1 !== 1'b1 || bus.rf_rd_addr1 !== 5'd5) begin
      errors++; $display("FAIL raw_resume: got ready=%b en1=%b addr1=%0d expected 1 1 5", bus.iss_ready, bus.rf_rd_en1, bus.rf_rd_addr1);
    end
    tick();
    idle();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [3];
    exp_g[0] = 3'b001;
    exp_g[1] = 3'b010;
    exp_g[2] = 3'b100;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_busy = '0;
    for (int r = 1; r <= 3; r++) begin
      drive_issue(5'(r));
      #1;
      checks++;
      if (bus.iss_ready !== 1'b1) begin
        errors++; $display("FAIL rr_issue_%0d: got %b expected 1", r, bus.iss_ready);
      end
      tick();
      m_busy[r] = 1'b1;
    end
    idle();
    #1;
    checks++;
    if (bus.busy !== m_busy || bus.pending_cnt !== 6'd3) begin
      errors++; $display("FAIL rr_busy3: got busy=%h cnt=%0d expected busy=%h cnt=3", bus.busy, bus.pending_cnt, m_busy);
    end
    set_wb(0, 5'd1, 32'hA000_0001);
    set_wb(1, 5'd2, 32'hA000_0002);
    set_wb(2, 5'd3, 32'hA000_0003);
    push_exp(5'd1, 32'hA000_0001);
    push_exp(5'd2, 32'hA000_0002);
    push_exp(5'd3, 32'hA000_0003);
    bus.wb_valid = 3'b111;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if (bus.wb_ready !== exp_g[j]) begin
        errors++; $display("FAIL rr_grant_%0d: got %b expected %b", j, bus.wb_ready, exp_g[j]);
      end
      checks++;
      e = sb.pop_front();
      if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== e.a || bus.rf_wr_data !== e.d) begin
        errors++; $display("FAIL rr_write_%0d: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h", j, bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, e.a, e.d);
      end
      tick();
      bus.wb_valid = bus.wb_valid & ~exp_g[j];
      m_busy[j+1] = 1'b0;
    end
    #1;
    checks++;
    if (bus.busy !== m_busy || bus.pending_cnt !== 6'd0) begin
      errors++; $display("FAIL rr_drained: got busy=%h cnt=%0d expected busy=%h cnt=0", bus.busy, bus.pending_cnt, m_busy);
    end
    drive_issue(5'd4);
    tick();
    m_busy[4] = 1'b1;
    drive_issue(5'd6);
    tick();
    m_busy[6] = 1'b1;
    idle();
    set_wb(0, 5'd0, 32'h0BAD_0000);
    bus.wb_valid = 3'b001;
    #1;
    checks++;
    if (bus.wb_ready !== 3'b001 || bus.rf_wr_en !== 1'b0) begin
      errors++; $display("FAIL rr_r0_grant: got ready=%b en=%b expected 001 0", bus.wb_ready, bus.rf_wr_en);
    end
    tick();
    set_wb(0, 5'd4, 32'hB000_0004);
    set_wb(2, 5'd6, 32'hB000_0006);
    push_exp(5'd6, 32'hB000_0006);
    push_exp(5'd4, 32'hB000_0004);
    bus.wb_valid = 3'b101;
    #1;
    checks++;
    if (bus.wb_ready !== 3'b100) begin
      errors++; $display("FAIL rr_restart_first: got %b expected 100", bus.wb_ready);
    end
    checks++;
    e = sb.pop_front();
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== e.a || bus.rf_wr_data !== e.d) begin
      errors++; $display("FAIL rr_restart_write0: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h", bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, e.a, e.d);
    end
    tick();
    bus.wb_valid = 3'b001;
    m_busy[6] = 1'b0;
    #1;
    checks++;
    if (bus.wb_ready !== 3'b001) begin
      errors++; $display("FAIL rr_restart_second: got %b expected 001", bus.wb_ready);
    end
    checks++;
    e = sb.pop_front();
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== e.a || bus.rf_wr_data !== e.d) begin
      errors++; $display("FAIL rr_restart_write1: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h", bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, e.a, e.d);
    end
    tick();
    bus.wb_valid = '0;
    m_busy[4] = 1'b0;
    #1;
    checks++;
    if (bus.busy !== m_busy || bus.pending_cnt !== 6'($countones(m_busy))) begin
      errors++; $display("FAIL rr_final_busy: got busy=%h cnt=%0d expected busy=%h", bus.busy, bus.pending_cnt, m_busy);
    end
  endtask

  task automatic test_r0();
    drive_issue(5'd0);
    bus.iss_rs1      = 5'd0;
    bus.iss_rs1_used = 1'b1;
    #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++; $display("FAIL r0_issue_ready: got %b expected 1", bus.iss_ready);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy !== m_busy || bus.pending_cnt !== 6'($countones(m_busy))) begin
      errors++; $display("FAIL r0_busy_unchanged: got busy=%h cnt=%0d expected busy=%h", bus.busy, bus.pending_cnt, m_busy);
    end
    set_wb(1, 5'd0, 32'h1234_5678);
    bus.wb_valid = 3'b010;
    #1;
    checks++;
    if (bus.wb_ready !== 3'b010 || bus.rf_wr_en !== 1'b0) begin
      errors++; $display("FAIL r0_wb: got ready=%b en=%b expected 010 0", bus.wb_ready, bus.rf_wr_en);
    end
    tick();
    bus.wb_valid = '0;
    #1;
    checks++;
    if (bus.wb_err !== 1'b0 || bus.busy !== m_busy) begin
      errors++; $display("FAIL r0_no_err: got err=%b busy=%h expected 0 %h", bus.wb_err, bus.busy, m_busy);
    end
  endtask

  task automatic test_waw();
    drive_issue(5'd7);
    #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++; $display("FAIL waw_first_ready: got %b expected 1", bus.iss_ready);
    end
    tick();
    m_busy[7] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.iss_ready !== 1'b0) begin
        errors++; $display("FAIL waw_stall_%0d: got %b expected 0", c, bus.iss_ready);
      end
      tick();
    end
    set_wb(2, 5'd7, 32'hC000_0007);
    push_exp(5'd7, 32'hC000_0007);
    bus.wb_valid = 3'b100;
    #1;
    checks++;
    if (bus.iss_ready !== 1'b0 || bus.wb_ready !== 3'b100) begin
      errors++; $display("FAIL waw_wb_cycle: got ready=%b grant=%b expected 0 100", bus.iss_ready, bus.wb_ready);
    end
    checks++;
    e = sb.pop_front();
    if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== e.a || bus.rf_wr_data !== e.d) begin
      errors++; $display("FAIL waw_write: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h", bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, e.a, e.d);
    end
    tick();
    bus.wb_valid = '0;
    m_busy[7] = 1'b0;
    #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++; $display("FAIL waw_second_issue: got %b expected 1", bus.iss_ready);
    end
    tick();
    m_busy[7] = 1'b1;
    idle();
    #1;
    checks++;
    if (bus.busy !== m_busy || bus.pending_cnt !== 6'($countones(m_busy))) begin
      errors++; $display("FAIL waw_rebusy: got busy=%h cnt=%0d expected busy=%h", bus.busy, bus.pending_cnt, m_busy);
    end
    set_wb(0, 5'd7, 32'hC000_0008);
    push_exp(5'd7, 32'hC000_0008);
    bus.wb_valid = 3'b001;
    #1;
    checks++;
    e = sb.pop_front();
    if (bus.wb_ready !== 3'b001 || bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== e.a || bus.rf_wr_data !== e.d) begin
      errors++; $display("FAIL waw_drain: got grant=%b en=%b addr=%0d data=%h expected 001 1 %0d %h", bus.wb_ready, bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, e.a, e.d);
    end
    tick();
    bus.wb_valid = '0;
    m_busy[7] = 1'b0;
  endtask

  task automatic test_wb_err();
    set_wb(1, 5'd9, 32'hE000_0009);
    push_exp(5'd9, 32'hE000_0009);
    bus.wb_valid = 3'b010;
    #1;
    checks++;
    e = sb.pop_front();
    if (bus.wb_ready !== 3'b010 || bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== e.a || bus.rf_wr_data !== e.d) begin
      errors++; $display("FAIL err_write_performed: got grant=%b en=%b addr=%0d data=%h expected 010 1 %0d %h", bus.wb_ready, bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, e.a, e.d);
    end
    checks++;
    if (bus.wb_err !== 1'b0) begin
      errors++; $display("FAIL err_before: got %b expected 0", bus.wb_err);
    end
    tick();
    bus.wb_valid = '0;
    #1;
    checks++;
    if (bus.wb_err !== 1'b1) begin
      errors++; $display("FAIL err_set: got %b expected 1", bus.wb_err);
    end
    repeat (3) tick();
    checks++;
    if (bus.wb_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b expected 1", bus.wb_err);
    end
    checks++;
    if (bus.busy !== m_busy || bus.pending_cnt !== 6'($countones(m_busy))) begin
      errors++; $display("FAIL err_busy: got busy=%h cnt=%0d expected busy=%h", bus.busy, bus.pending_cnt, m_busy);
    end
  endtask

  task automatic test_reset_mid();
    drive_issue(5'd4);
    tick();
    m_busy[4] = 1'b1;
    drive_issue(5'd6);
    tick();
    m_busy[6] = 1'b1;
    idle();
    #1;
    checks++;
    if (bus.busy !== m_busy || bus.pending_cnt !== 6'd2) begin
      errors++; $display("FAIL mid_pre_busy: got busy=%h cnt=%0d expected busy=%h cnt=2", bus.busy, bus.pending_cnt, m_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_busy = '0;
    #1;
    checks++;
    if (bus.busy !== 32'h0 || bus.pending_cnt !== 6'd0 || bus.wb_err !== 1'b0) begin
      errors++; $display("FAIL mid_cleared: got busy=%h cnt=%0d err=%b expected 0 0 0", bus.busy, bus.pending_cnt, bus.wb_err);
    end
    bus.wb_addr  = '0;
    bus.wb_valid = 3'b111;
    #1;
    checks++;
    if (bus.wb_ready !== 3'b001) begin
      errors++; $display("FAIL mid_rr_ptr: got %b expected 001", bus.wb_ready);
    end
    tick();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    m_busy = '0;
    idle();
    test_reset();
    test_raw();
    test_round_robin();
    test_r0();
    test_waw();
    test_wb_err();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Issue/writeback controller for the 32x32 two-read/one-write register file.
- Keeps a per-register busy scoreboard and stalls issue on RAW/WAW hazards.
- Round-robin arbitrates NREQ writeback units (ALU, load, mul/div) onto the single write port.
- Drives the regfile read enables and addresses for the issuing instruction.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
AW, 5, register address width (2**AW registers)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- iss_valid  in  1  instruction presented for issue
- iss_ready  out  1  issue accepted this cycle when iss_valid & iss_ready
- iss_rs1, iss_rs2  in  AW  source register addresses
- iss_rs1_used, iss_rs2_used  in  1  source operand actually read
- iss_rd  in  AW  destination register
- iss_rd_wr  in  1  instruction writes iss_rd
- rf_rd_en1, rf_rd_en2  out  1  regfile read enables
- rf_rd_addr1, rf_rd_addr2  out  AW  regfile read addresses
- wb_valid  in  NREQ  writeback request per unit
- wb_addr  in  NREQ*AW  packed destination per unit; unit i at [i*AW +: AW]
- wb_data  in  NREQ*XLEN  packed data per unit
- wb_ready  out  NREQ  one-hot grant; writeback consumed on valid & ready
- rf_wr_en  out  1  regfile write enable
- rf_wr_addr  out  AW  regfile write address
- rf_wr_data  out  XLEN  regfile write data
- busy  out  2**AW  scoreboard, bit r = write to r outstanding
- pending_cnt  out  AW+1  population count of busy
- wb_err  out  1  sticky: writeback to a non-busy register

Behaviour:
State:
- busy[2**AW-1:0] register.
- rr_ptr (clog2 NREQ bits).
- pending_cnt register.
- wb_err register.

Reset (rst high at posedge):
- busy=0, rr_ptr=0, pending_cnt=0, wb_err=0.
- While rst is high, iss_ready=0, wb_ready=0 and rf_wr_en=0 combinationally.
- A reset asserted mid-operation discards all outstanding scoreboard state; in-flight requesters must themselves be reset.

Issue (combinational):
- haz = (rs1_used & busy[rs1]) | (rs2_used & busy[rs2]) | (rd_wr & busy[rd]).
- busy[0] is never set, so r0 never causes a hazard.
- iss_ready = ~rst & ~haz; it is independent of iss_valid.
- rf_rd_enN = iss_valid & iss_rsN_used; rf_rd_addrN = iss_rsN.
- The regfile has no write-through, so a same-cycle writeback to a source register still stalls. The instruction issues the following cycle.

Issue accept:
- On iss_valid & iss_ready & iss_rd_wr & iss_rd!=0, set busy[iss_rd] at the next posedge.

Writeback arbitration (combinational):
- Search wb_valid starting at index rr_ptr, wrapping modulo NREQ.
- The first valid unit g is granted: wb_ready = one-hot(g). At most one grant per cycle.
- If no unit is valid, wb_ready=0 and rr_ptr is unchanged.
- On a grant, rr_ptr <= (g+1) mod NREQ at the posedge.
- Ungranted units must hold valid/addr/data stable until granted.

Write port (zero latency, combinational from grant):
- rf_wr_en = grant & wb_addr[g]!=0.
- rf_wr_addr = wb_addr[g]; rf_wr_data = wb_data[g].
- A grant to r0 is consumed with rf_wr_en=0 and no scoreboard change.
- The regfile commits at the same posedge. Issue in the next cycle reads the new value.

Scoreboard update, at the posedge with grant to g, addr a != 0:
- Clear busy[a].
- If busy[a] was already 0, set wb_err=1 (sticky until rst); the write is still performed.
- If the same cycle also issues with rd==a, set takes priority and busy[a] stays 1. This case is only reachable in the wb_err situation, since a busy rd stalls issue.

pending_cnt:
- Tracks popcount(busy) registered: +1 on set only, -1 on clear only, unchanged when both or neither occur.
- Max value 31, so it cannot overflow.

Test Plan:
- Reset: hold rst 2 cycles with wb_valid=3'b111 and iss_valid=1 -> wb_ready=0, rf_wr_en=0, iss_ready=0; after release busy=0, pending_cnt=0.
- RAW stall:
  - Issue rd=5 -> busy[5]=1, pending_cnt=1.
  - Next, issue rs1=5 used -> iss_ready=0.
  - Unit 1 writes addr 5 data 0xDEADBEEF -> rf_wr_en=1 that cycle, busy[5]=0 after.
  - Following cycle iss_ready=1, rf_rd_addr1=5.
- Round-robin:
  - busy for 1,2,3; units 0/1/2 all valid with addrs 1/2/3, rr_ptr=0.
  - Grants 001, 010, 100 on consecutive cycles; rf_wr_addr 1,2,3.
  - Restart with only units 0 and 2 valid and rr_ptr=1 -> grant 100 first.
- r0 handling: issue rd=0 -> busy unchanged, no stall. Writeback addr 0 -> wb_ready high, rf_wr_en=0, wb_err stays 0.
- WAW and error:
  - Issue rd=7 twice back-to-back -> second stalled until the wb to 7 is granted.
  - A wb to addr 9 with busy[9]=0 -> wb_err=1 and remains set until rst.
- Reset mid-operation: busy for 4,6, pending_cnt=2, assert rst one cycle -> busy=0, pending_cnt=0, rr_ptr=0, wb_err=0.
